mem_bus_arbiter: RTL

Shares the single SRAM-like memory port between the instruction-fetch requester and the data-access requester, which is driven by the decoder's memen/memwrite controls in MEM. It sequences one outstanding transaction at a time through an address phase and a data phase. Data requests take priority, and a starvation guard keeps fetch moving. The block sits between the pipeline's fetch/MEM stages and the cache or bridge master.

---
 rtl/mem_bus_arbiter_pkg.sv | 40 ++++
 rtl/mem_bus_arbiter_if.sv | 55 +++++
 rtl/mem_bus_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic [1:0] STARVE_MAX = 2'd2;

    // Latched downstream request payload.
    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [3:0]        wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // Starvation counter after a data grant: count while fetch waits, saturating.
    function automatic logic [1:0] starve_after_data(input logic [1:0] cnt,
                                                     input logic       inst_pending);
        if (!inst_pending) begin
            return 2'd0;
        end
        return (cnt == STARVE_MAX) ? STARVE_MAX : 2'(cnt + 2'd1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Fetch, data and downstream memory handshake signals of the arbiter.
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    logic              mem_req;
    logic              mem_wr;
    logic [1:0]        mem_size;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    // Arbiter side.
    modport master (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output busy
    );

    // Requester / memory side.
    modport slave (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  busy
    );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like port between fetch and data requesters, one
// transaction at a time, data first with a starvation guard for fetch.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.master bus
);

    state_t     state;
    logic       owner;
    logic [1:0] starve_cnt;
    req_t       req_q;
    logic       mem_req_q;

    logic grant_data_c;
    logic grant_inst_c;
    logic addr_ok_c;
    logic data_ok_c;

    // Grant selection in IDLE: data wins unless fetch has waited STARVE_MAX grants.
    always_comb begin
        grant_data_c = bus.data_req && !(bus.inst_req && (starve_cnt == STARVE_MAX));
        grant_inst_c = bus.inst_req && !grant_data_c;
    end

    // Downstream handshakes qualified by the active phase; stale ones in IDLE are dropped.
    always_comb begin
        addr_ok_c = (state == ADDR) && bus.mem_addr_ok;
        data_ok_c = ((state == ADDR) && bus.mem_addr_ok && bus.mem_data_ok) ||
                    ((state == DATA) && bus.mem_data_ok);
    end

    // Transaction sequencer: grant, address phase, data phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_INST;
            starve_cnt <= 2'd0;
            req_q      <= '0;
            mem_req_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_data_c) begin
                        owner      <= OWN_DATA;
                        starve_cnt <= starve_after_data(starve_cnt, bus.inst_req);
                        req_q      <= '{wr:    bus.data_wr,
                                        size:  bus.data_size,
                                        wstrb: bus.data_wstrb,
                                        addr:  bus.data_addr,
                                        wdata: bus.data_wdata};
                        mem_req_q  <= 1'b1;
                        state      <= ADDR;
                    end else if (grant_inst_c) begin
                        owner      <= OWN_INST;
                        starve_cnt <= 2'd0;
                        req_q      <= '{wr:    1'b0,
                                        size:  SIZE_WORD,
                                        wstrb: 4'h0,
                                        addr:  bus.inst_addr,
                                        wdata: '0};
                        mem_req_q  <= 1'b1;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.mem_addr_ok) begin
                        mem_req_q <= 1'b0;
                        state     <= bus.mem_data_ok ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (bus.mem_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_wr    = req_q.wr;
    assign bus.mem_size  = req_q.size;
    assign bus.mem_wstrb = req_q.wstrb;
    assign bus.mem_addr  = req_q.addr;
    assign bus.mem_wdata = req_q.wdata;

    assign bus.inst_addr_ok = addr_ok_c && (owner == OWN_INST);
    assign bus.inst_data_ok = data_ok_c && (owner == OWN_INST);
    assign bus.data_addr_ok = addr_ok_c && (owner == OWN_DATA);
    assign bus.data_data_ok = data_ok_c && (owner == OWN_DATA);

    assign bus.inst_rdata = bus.mem_rdata;
    assign bus.data_rdata = bus.mem_rdata;

    assign bus.busy = (state != IDLE);

endmodule
